// File: rtl/shapool_host_link.sv
// Host-side master for the shapool device link.
// Broadcasts a job frame on the global SPI bus (sck0/sdo0/cs0_n).
// Then it waits for the shared open-drain ready_n line to go low.
// Finally it clocks result bits out of the device daisy chain (sck1/sdi1/cs1_n).
module shapool_host_link #(
  parameter int JOB_CONFIG_WIDTH  = 360,
  parameter int RESULT_DATA_WIDTH = 32,
  parameter int N_DEVICES         = 1,
  parameter int SCK_HALF          = 2,
  parameter int TIMEOUT_CYCLES    = 0
) (
  input  logic                                      clk_in,
  input  logic                                      reset_in,
  input  logic                                      start_in,
  input  logic                                      abort_in,
  input  logic [JOB_CONFIG_WIDTH-1:0]               job_in,
  output logic                                      busy_out,
  output logic                                      result_valid_out,
  output logic [RESULT_DATA_WIDTH*N_DEVICES-1:0]    result_out,
  output logic                                      timeout_out,
  output logic                                      sck0_out,
  output logic                                      sdo0_out,
  output logic                                      cs0_n_out,
  output logic                                      sck1_out,
  output logic                                      cs1_n_out,
  input  logic                                      sdi1_in,
  input  logic                                      ready_n_in
);

  localparam int RW   = RESULT_DATA_WIDTH * N_DEVICES;
  localparam int MAXN = (JOB_CONFIG_WIDTH > RW) ? JOB_CONFIG_WIDTH : RW;
  localparam int BW   = $clog2(MAXN + 1);
  localparam int HW   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
  localparam logic [BW-1:0] JOB_LAST  = BW'(JOB_CONFIG_WIDTH - 1);
  localparam logic [BW-1:0] RES_LAST  = BW'(RW - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_READY, READ} state_t;
  // Sub-phase of one SPI bit: low half, high half, or the trailing CS hold.
  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_HOLD} phase_t;

  state_t                  state_r;
  phase_t                  phase_r;
  logic [HW-1:0]           half_cnt_r;
  logic [BW-1:0]           bit_cnt_r;
  logic [TW-1:0]           tmo_cnt_r;
  logic                    low_seen_r;
  logic                    ready_meta_r;
  logic                    ready_sync_r;
  logic [JOB_CONFIG_WIDTH-1:0] tx_shift_r;
  logic [RW-1:0]           rx_shift_r;
  logic                    half_last_s;

  assign half_last_s = (half_cnt_r == HALF_LAST);

  // Two-flop synchronizer for the asynchronous wired ready line (idles high).
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ready_meta_r <= 1'b1;
      ready_sync_r <= 1'b1;
    end else begin
      ready_meta_r <= ready_n_in;
      ready_sync_r <= ready_meta_r;
    end
  end

  // Link sequencer: job broadcast, ready wait, daisy-chain readback.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r          <= IDLE;
      phase_r          <= PH_LOW;
      half_cnt_r       <= '0;
      bit_cnt_r        <= '0;
      tmo_cnt_r        <= '0;
      low_seen_r       <= 1'b0;
      tx_shift_r       <= '0;
      rx_shift_r       <= '0;
      busy_out         <= 1'b0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
      timeout_out      <= 1'b0;
      sck0_out         <= 1'b0;
      sdo0_out         <= 1'b0;
      cs0_n_out        <= 1'b1;
      sck1_out         <= 1'b0;
      cs1_n_out        <= 1'b1;
    end else begin
      result_valid_out <= 1'b0;
      timeout_out      <= 1'b0;
      if (abort_in) begin
        // Abandon whatever is in flight; also keeps IDLE when paired with start.
        state_r    <= IDLE;
        phase_r    <= PH_LOW;
        half_cnt_r <= '0;
        bit_cnt_r  <= '0;
        busy_out   <= 1'b0;
        sck0_out   <= 1'b0;
        sdo0_out   <= 1'b0;
        cs0_n_out  <= 1'b1;
        sck1_out   <= 1'b0;
        cs1_n_out  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_in) begin
              state_r    <= LOAD;
              tx_shift_r <= job_in;
              busy_out   <= 1'b1;
              cs0_n_out  <= 1'b0;
              sdo0_out   <= job_in[JOB_CONFIG_WIDTH-1];
              phase_r    <= PH_LOW;
              half_cnt_r <= '0;
              bit_cnt_r  <= '0;
            end
          end
          LOAD: begin
            if (half_last_s) begin
              half_cnt_r <= '0;
              case (phase_r)
                PH_LOW: begin
                  phase_r  <= PH_HIGH;
                  sck0_out <= 1'b1;
                end
                PH_HIGH: begin
                  sck0_out <= 1'b0;
                  if (bit_cnt_r == JOB_LAST) begin
                    phase_r <= PH_HOLD;
                  end else begin
                    phase_r    <= PH_LOW;
                    bit_cnt_r  <= bit_cnt_r + BW'(1);
                    sdo0_out   <= tx_shift_r[JOB_CONFIG_WIDTH-2];
                    tx_shift_r <= {tx_shift_r[JOB_CONFIG_WIDTH-2:0], 1'b0};
                  end
                end
                PH_HOLD: begin
                  cs0_n_out  <= 1'b1;
                  sdo0_out   <= 1'b0;
                  state_r    <= WAIT_READY;
                  tmo_cnt_r  <= '0;
                  low_seen_r <= 1'b0;
                end
                default: phase_r <= PH_LOW;
              endcase
            end else begin
              half_cnt_r <= half_cnt_r + HW'(1);
            end
          end
          WAIT_READY: begin
            // Two consecutive synchronized lows reject single-cycle glitches.
            if (!ready_sync_r && low_seen_r) begin
              state_r    <= READ;
              cs1_n_out  <= 1'b0;
              sck1_out   <= 1'b0;
              phase_r    <= PH_LOW;
              half_cnt_r <= '0;
              bit_cnt_r  <= '0;
              rx_shift_r <= '0;
            end else if ((TIMEOUT_CYCLES > 0) && (tmo_cnt_r == TMO_LAST)) begin
              state_r     <= IDLE;
              busy_out    <= 1'b0;
              timeout_out <= 1'b1;
            end else begin
              low_seen_r <= !ready_sync_r;
              if (TIMEOUT_CYCLES > 0) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
              end
            end
          end
          READ: begin
            if (half_last_s) begin
              half_cnt_r <= '0;
              case (phase_r)
                PH_LOW: begin
                  phase_r  <= PH_HIGH;
                  sck1_out <= 1'b1;
                end
                PH_HIGH: begin
                  // Sample on the edge that returns SCK low.
                  sck1_out   <= 1'b0;
                  rx_shift_r <= {rx_shift_r[RW-2:0], sdi1_in};
                  if (bit_cnt_r == RES_LAST) begin
                    phase_r <= PH_HOLD;
                  end else begin
                    phase_r   <= PH_LOW;
                    bit_cnt_r <= bit_cnt_r + BW'(1);
                  end
                end
                PH_HOLD: begin
                  cs1_n_out        <= 1'b1;
                  result_out       <= rx_shift_r;
                  result_valid_out <= 1'b1;
                  busy_out         <= 1'b0;
                  state_r          <= IDLE;
                end
                default: phase_r <= PH_LOW;
              endcase
            end else begin
              half_cnt_r <= half_cnt_r + HW'(1);
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shapool_host_link.sv
// Self-checking bench for shapool_host_link: a cycle-level behavioural model
// derived from frame timing arithmetic, a simple daisy-chain device, and
// directed plus randomized transactions.
module tb_shapool_host_link;

  localparam int JW       = 360;
  localparam int RDW      = 32;
  localparam int ND       = 3;
  localparam int RW       = RDW * ND;
  localparam int H        = 2;
  localparam int TMO      = 100;
  localparam int LOAD_LEN = JW * 2 * H + H;
  localparam int READ_LEN = RW * 2 * H + H;

  logic          clk_in = 1'b0;
  logic          reset_in, start_in, abort_in, sdi1_in, ready_n_in;
  logic [JW-1:0] job_in;
  logic          busy_out, result_valid_out, timeout_out;
  logic [RW-1:0] result_out;
  logic          sck0_out, sdo0_out, cs0_n_out, sck1_out, cs1_n_out;

  always #5 clk_in = ~clk_in;

  shapool_host_link #(
    .JOB_CONFIG_WIDTH(JW), .RESULT_DATA_WIDTH(RDW), .N_DEVICES(ND),
    .SCK_HALF(H), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
    .job_in(job_in), .busy_out(busy_out), .result_valid_out(result_valid_out),
    .result_out(result_out), .timeout_out(timeout_out), .sck0_out(sck0_out),
    .sdo0_out(sdo0_out), .cs0_n_out(cs0_n_out), .sck1_out(sck1_out),
    .cs1_n_out(cs1_n_out), .sdi1_in(sdi1_in), .ready_n_in(ready_n_in)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [JW-1:0] act, input logic [JW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 job frame, 2 waiting for ready, 3 readback.
  // k counts clocks since the current frame began; w counts waiting clocks.
  int            mode = 0, k = 0, w = 0;
  bit            m_on = 1'b0, e_valid = 1'b0, e_tmo = 1'b0;
  logic          h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;
  logic [JW-1:0] m_job = '0;
  logic [RW-1:0] m_res = '0;
  logic [RW-1:0] dev_stream = '0;

  initial begin
    forever begin
      @(posedge clk_in);
      e_valid = 1'b0;
      e_tmo   = 1'b0;
      if (reset_in === 1'b1) begin
        mode = 0; k = 0; w = 0; m_res = '0;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
        m_on = 1'b1;
      end else begin
        case (mode)
          0: if (!abort_in && start_in) begin mode = 1; k = 0; m_job = job_in; end
          1: if (abort_in) mode = 0;
             else begin k++; if (k == LOAD_LEN) begin mode = 2; w = 0; end end
          2: if (abort_in) mode = 0;
             else begin
               w++;
               // ready_n as seen two and three clocks ago (after 2-FF sync)
               if (w >= 2 && h2 == 1'b0 && h3 == 1'b0) begin mode = 3; k = 0; end
               else if (w == TMO) begin mode = 0; e_tmo = 1'b1; end
             end
          3: if (abort_in) mode = 0;
             else begin
               k++;
               if (k == READ_LEN) begin mode = 0; e_valid = 1'b1; m_res = dev_stream; end
             end
          default: mode = 0;
        endcase
        h3 = h2; h2 = h1; h1 = ready_n_in;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_in);
      if (m_on) begin
        chk("busy", busy_out, mode != 0);
        chk("cs0_n", cs0_n_out, mode != 1);
        chk("sck0", sck0_out, (mode == 1) && (k < 2*H*JW) && ((k % (2*H)) >= H));
        if (mode == 1 && k < 2*H*JW) chk("sdo0", sdo0_out, m_job[JW-1-k/(2*H)]);
        else if (mode != 1) chk("sdo0", sdo0_out, 1'b0);
        chk("cs1_n", cs1_n_out, mode != 3);
        chk("sck1", sck1_out, (mode == 3) && (k < 2*H*RW) && ((k % (2*H)) >= H));
        chk("result_valid", result_valid_out, e_valid);
        chk("timeout", timeout_out, e_tmo);
        chk("result", result_out, m_res);
      end
    end
  end

  // Daisy-chain device: presents the next stream bit on each sck1 rising edge.
  int   dev_idx = 0;
  logic prev_sck1 = 1'b0;
  initial begin
    sdi1_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (cs1_n_out !== 1'b0) dev_idx = 0;
      else if (sck1_out === 1'b1 && prev_sck1 === 1'b0) begin
        if (dev_idx < RW) sdi1_in = dev_stream[RW-1-dev_idx];
        dev_idx++;
      end
      prev_sck1 = sck1_out;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic run_load(input logic [JW-1:0] job, input bit extras,
                          output int cs_low, output int rises, output logic [JW-1:0] cap);
    int   cyc;
    bit   seen_low, done;
    logic prev;
    cs_low = 0; rises = 0; cap = '0; prev = 1'b0; seen_low = 1'b0; done = 1'b0; cyc = 0;
    @(negedge clk_in); job_in = job; start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    while (!done && cyc < 3000) begin
      if (cs0_n_out === 1'b0) begin cs_low++; seen_low = 1'b1; end
      else if (seen_low) done = 1'b1;
      if (!done) begin
        if (sck0_out === 1'b1 && prev === 1'b0) begin rises++; cap = {cap[JW-2:0], sdo0_out}; end
        prev = sck0_out;
        if (extras && cyc == 10) begin start_in = 1'b1; job_in = ~job; end
        if (extras && cyc == 11) start_in = 1'b0;
        if (extras && cyc == 500) ready_n_in = 1'b0;
        if (extras && cyc == 504) ready_n_in = 1'b1;
        cyc++;
        @(negedge clk_in);
      end
    end
    chk("load_done", done, 1'b1);
  endtask

  task automatic run_read(input logic [RW-1:0] stream, input int delay,
                          output int pulses, output int valids,
                          output logic [RW-1:0] res, output logic busy_at_valid);
    int   cyc, after;
    bit   got;
    logic prev;
    pulses = 0; valids = 0; res = '0; busy_at_valid = 1'b1; got = 1'b0; after = 0; cyc = 0;
    prev = 1'b0;
    dev_stream = stream;
    repeat (delay) @(negedge clk_in);
    ready_n_in = 1'b0;
    while (after < 5 && cyc < 2000) begin
      @(negedge clk_in);
      cyc++;
      if (sck1_out === 1'b1 && prev === 1'b0) pulses++;
      prev = sck1_out;
      if (result_valid_out === 1'b1) begin
        valids++;
        res = result_out;
        busy_at_valid = busy_out;
        got = 1'b1;
      end
      if (got) after++;
    end
    ready_n_in = 1'b1;
    chk("read_done", got, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  logic [JW-1:0] a5_job, rjob, cap;
  logic [RW-1:0] rstream, res;
  logic          bav;
  int            cs_low, rises, pulses, valids, tcyc, cs1_low, cyc;

  initial begin
    reset_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; job_in = '0; ready_n_in = 1'b1;
    a5_job = {45{8'hA5}};
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_cs0_n", cs0_n_out, 1'b1);
    chk("rst_cs1_n", cs1_n_out, 1'b1);
    chk("rst_sck0", sck0_out, 1'b0);
    chk("rst_sck1", sck1_out, 1'b0);
    chk("rst_sdo0", sdo0_out, 1'b0);
    chk("rst_valid", result_valid_out, 1'b0);
    chk("rst_timeout", timeout_out, 1'b0);
    chk("rst_result", result_out, '0);
    reset_in = 1'b0;

    // Job load with an ignored start while busy and a ready glitch during LOAD.
    run_load(a5_job, 1'b1, cs_low, rises, cap);
    chk("cs0_low_cycles", cs_low, 1442);
    chk("sck0_rises", rises, 360);
    chk("job_bits", cap, {45{8'hA5}});
    chk("sdo0_after_cs", sdo0_out, 1'b0);
    run_read(96'h111111112222222233333333, 5, pulses, valids, res, bav);
    chk("sck1_pulses", pulses, 96);
    chk("valid_pulses", valids, 1);
    chk("chain_result", res, 96'h111111112222222233333333);
    chk("busy_with_valid", bav, 1'b0);

    // Glitch then timeout.
    run_load(a5_job ^ {JW{1'b1}}, 1'b0, cs_low, rises, cap);
    tcyc = -1; cs1_low = 0; cyc = 0;
    while (tcyc < 0 && cyc < 300) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 20) ready_n_in = 1'b0;
      if (cyc == 21) ready_n_in = 1'b1;
      if (cs1_n_out === 1'b0) cs1_low++;
      if (timeout_out === 1'b1) tcyc = cyc;
    end
    chk("timeout_cycles", tcyc, 100);
    chk("cs1_never_low", cs1_low, 0);

    // Abort in the middle of the job frame.
    @(negedge clk_in); job_in = a5_job; start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    rises = 0; cyc = 0;
    while (rises < 100 && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
      if (sck0_out === 1'b1 && sck0_out !== prev_sck1 && cyc > 0) begin end
      if (sck0_out === 1'b1 && cap[0] === 1'b0) rises++;
      cap[0] = sck0_out;
    end
    abort_in = 1'b1;
    @(negedge clk_in); abort_in = 1'b0;
    chk("abort_cs0_n", cs0_n_out, 1'b1);
    chk("abort_sck0", sck0_out, 1'b0);
    chk("abort_busy", busy_out, 1'b0);

    // Abort and start together in IDLE.
    abort_in = 1'b1; start_in = 1'b1;
    @(negedge clk_in); abort_in = 1'b0; start_in = 1'b0;
    chk("abort_start_busy", busy_out, 1'b0);
    repeat (3) @(negedge clk_in);
    chk("abort_start_cs0_n", cs0_n_out, 1'b1);

    // Randomized transactions, including abort in WAIT and reset during READ.
    for (int it = 0; it < 8; it++) begin
      rjob = '0;
      for (int j = 0; j < 12; j++) rjob = {rjob[JW-33:0], 32'($urandom())};
      rstream = {32'($urandom()), 32'($urandom()), 32'($urandom())};
      run_load(rjob, 1'b0, cs_low, rises, cap);
      chk("rnd_job_bits", cap, rjob);
      if (it == 2) begin
        repeat (30) @(negedge clk_in);
        abort_in = 1'b1;
        @(negedge clk_in); abort_in = 1'b0;
        chk("rnd_abort_busy", busy_out, 1'b0);
      end else if (it == 5) begin
        dev_stream = rstream;
        ready_n_in = 1'b0;
        cyc = 0;
        while (cs1_n_out !== 1'b0 && cyc < 200) begin @(negedge clk_in); cyc++; end
        repeat ($urandom_range(10, 200)) @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in); reset_in = 1'b0; ready_n_in = 1'b1;
        chk("rnd_reset_result", result_out, '0);
        chk("rnd_reset_cs1_n", cs1_n_out, 1'b1);
      end else begin
        run_read(rstream, $urandom_range(0, 60), pulses, valids, res, bav);
        chk("rnd_result", res, rstream);
        chk("rnd_valids", valids, 1);
      end
      repeat ($urandom_range(1, 8)) @(negedge clk_in);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
